// File: rtl/retro_catc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : retro_catc_pkg
// Purpose  : Shared types and helpers for the retro clock-and-timing
//            controller (state encoding, credit width, parameter checks).
// Revision : 1.0 - initial release
// ============================================================================
package retro_catc_pkg;

  // Controller operating states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STALL   = 2'd2,
    CATCHUP = 2'd3
  } catc_state_t;

  // Bits needed to hold 0..max_credit banked ticks
  function automatic int credit_w(input int max_credit);
    return $clog2(max_credit + 1);
  endfunction

  // Legal parameter combination: accumulator cannot overflow, target rate
  // below half the fabric clock, channel count and credit depth in range.
  function automatic bit params_ok(input longint core_clock, input longint target_clock,
                                   input int channels, input int acc_width,
                                   input int max_credit);
    bit ok;
    ok = 1'b1;
    if (acc_width < 2 || acc_width > 62) ok = 1'b0;
    else if ((core_clock + 2 * target_clock) >= (64'sd1 <<< acc_width)) ok = 1'b0;
    if (2 * target_clock >= core_clock) ok = 1'b0;
    if (channels < 1 || channels > 16) ok = 1'b0;
    if (max_credit < 1) ok = 1'b0;
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/retro_catc_if.sv
`default_nettype none
// ============================================================================
// Module   : retro_catc_if
// Purpose  : Control/status bundle between the shim and the timing
//            controller. Names are from the controller's point of view.
// Revision : 1.0 - initial release
// ============================================================================
interface retro_catc_if #(
  parameter int CHANNELS = 3,
  parameter int CREDIT_W = 5
);
  logic                i_clk_en;
  logic [CHANNELS-1:0] i_delay;
  logic [CHANNELS-1:0] i_delay_mask;
  logic                i_speed_select;
  logic                i_overrun_clear;
  logic                o_clk_en_out;
  logic [CREDIT_W-1:0] o_credit;
  logic                o_stalled;
  logic                o_overrun;

  modport master (
    output i_clk_en, i_delay, i_delay_mask, i_speed_select, i_overrun_clear,
    input  o_clk_en_out, o_credit, o_stalled, o_overrun
  );

  modport slave (
    input  i_clk_en, i_delay, i_delay_mask, i_speed_select, i_overrun_clear,
    output o_clk_en_out, o_credit, o_stalled, o_overrun
  );
endinterface
`default_nettype wire

// File: rtl/retro_catc_phase_acc.sv
`default_nettype none
// ============================================================================
// Module   : retro_catc_phase_acc
// Purpose  : Fractional phase accumulator. Emits a one-cycle tick whenever
//            the accumulated target rate crosses the fabric clock rate.
//            Tick is combinational in the cycle the crossing happens.
// Revision : 1.0 - initial release
// ============================================================================
module retro_catc_phase_acc #(
  parameter int CORE_CLOCK   = 200000000,
  parameter int TARGET_CLOCK = 4194304,
  parameter int ACC_WIDTH    = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_enable,
  input  wire logic i_double,
  output logic      o_tick
);

  localparam logic [ACC_WIDTH-1:0] c_INC  = ACC_WIDTH'(TARGET_CLOCK);
  localparam logic [ACC_WIDTH-1:0] c_CORE = ACC_WIDTH'(CORE_CLOCK);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_inc;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_tick;

  assign w_inc  = i_double ? (c_INC << 1) : c_INC;
  assign w_sum  = r_acc + w_inc;
  assign w_tick = i_enable && (w_sum >= c_CORE);
  assign o_tick = w_tick;

  // Advance the phase only while enabled; subtract the period on each tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= w_tick ? (w_sum - c_CORE) : w_sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/retro_catc_multi.sv
`default_nettype none
// ============================================================================
// Module   : retro_catc_multi
// Purpose  : Clock-and-timing controller. Generates the core clock-enable
//            from a phase accumulator, holds it off while any unmasked
//            delay source is active, banks the missed ticks as credit and
//            replays them as catch-up pulses afterwards.
// Revision : 1.0 - initial release
// ============================================================================
module retro_catc_multi
  import retro_catc_pkg::*;
#(
  parameter int CORE_CLOCK   = 200000000,
  parameter int TARGET_CLOCK = 4194304,
  parameter int CHANNELS     = 3,
  parameter int ACC_WIDTH    = 32,
  parameter int MAX_CREDIT   = 16,
  parameter int MIN_GAP      = 0
) (
  input  wire logic     clk,
  input  wire logic     rst,
  retro_catc_if.slave   bus
);

  localparam int c_CREDIT_W = credit_w(MAX_CREDIT);
  localparam int c_GAP_W    = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [c_CREDIT_W-1:0] c_MAX_CREDIT = c_CREDIT_W'(MAX_CREDIT);
  localparam logic [c_GAP_W-1:0]    c_MIN_GAP    = c_GAP_W'(MIN_GAP);

  generate
    if (!params_ok(CORE_CLOCK, TARGET_CLOCK, CHANNELS, ACC_WIDTH, MAX_CREDIT)) begin : g_bad_params
      $error("retro_catc_multi: illegal parameter combination");
    end
  endgenerate

  catc_state_t             r_state, w_state_nxt;
  logic [c_CREDIT_W-1:0]   r_credit, w_credit_nxt;
  logic [c_GAP_W-1:0]      r_gap, w_gap_nxt;
  logic                    r_clk_en_out, r_stalled, r_overrun;
  logic                    w_del, w_tick, w_pulse, w_drop;
  logic [c_CREDIT_W-1:0]   w_credit_bank;
  logic                    w_bank_drop;

  assign w_del = |(bus.i_delay & ~bus.i_delay_mask);

  retro_catc_phase_acc #(
    .CORE_CLOCK   (CORE_CLOCK),
    .TARGET_CLOCK (TARGET_CLOCK),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_phase_acc (
    .clk      (clk),
    .rst      (rst),
    .i_enable (bus.i_clk_en),
    .i_double (bus.i_speed_select),
    .o_tick   (w_tick)
  );

  // Credit after banking this cycle's tick; a tick at full credit is lost
  assign w_bank_drop   = w_tick && (r_credit == c_MAX_CREDIT);
  assign w_credit_bank = (w_tick && !w_bank_drop) ? r_credit + 1'b1 : r_credit;

  // Next state, credit, gap and pulse decision for this cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_gap_nxt    = (r_gap != '0) ? r_gap - 1'b1 : r_gap;
    w_pulse      = 1'b0;
    w_drop       = 1'b0;
    if (!bus.i_clk_en) begin
      w_state_nxt = IDLE;
    end else if (w_del) begin
      w_credit_nxt = w_credit_bank;
      w_drop       = w_bank_drop;
      w_state_nxt  = STALL;
    end else begin
      unique case (r_state)
        RUN: begin
          w_pulse = w_tick;
        end
        CATCHUP: begin
          if (r_gap == '0) begin
            // A tick coinciding with a replay pulse cancels the decrement
            w_pulse   = 1'b1;
            w_gap_nxt = c_MIN_GAP;
            if (!w_tick) w_credit_nxt = r_credit - 1'b1;
          end else begin
            w_credit_nxt = w_credit_bank;
            w_drop       = w_bank_drop;
          end
          w_state_nxt = (w_credit_nxt == '0) ? RUN : CATCHUP;
        end
        default: begin
          // IDLE resuming or STALL releasing: no pulse, bank any tick first
          w_credit_nxt = w_credit_bank;
          w_drop       = w_bank_drop;
          w_state_nxt  = (w_credit_nxt == '0) ? RUN : CATCHUP;
        end
      endcase
    end
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_credit     <= '0;
      r_gap        <= '0;
      r_clk_en_out <= 1'b0;
      r_stalled    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_credit     <= w_credit_nxt;
      r_gap        <= w_gap_nxt;
      r_clk_en_out <= w_pulse;
      r_stalled    <= w_del;
      r_overrun    <= w_drop | (r_overrun & ~bus.i_overrun_clear);
    end
  end

  assign bus.o_clk_en_out = r_clk_en_out;
  assign bus.o_credit     = r_credit;
  assign bus.o_stalled    = r_stalled;
  assign bus.o_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_retro_catc_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_retro_catc_multi
// Purpose  : Directed bench for retro_catc_multi. Two instances share the
//            stimulus: A (MAX_CREDIT=8) and B (MAX_CREDIT=4, saturation).
//            CORE_CLOCK=16, TARGET_CLOCK=4 -> one tick per 4 enabled clocks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_retro_catc_multi;
  import retro_catc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_en = 1'b0;
  logic [2:0] delay = '0;
  logic [2:0] delay_mask = '0;
  logic       speed = 1'b0;
  logic       oclr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int pa = 0;
  int pb = 0;

  always #5 clk = ~clk;

  retro_catc_if #(.CHANNELS(3), .CREDIT_W(credit_w(8))) ifa ();
  retro_catc_if #(.CHANNELS(3), .CREDIT_W(credit_w(4))) ifb ();

  assign ifa.i_clk_en = clk_en;        assign ifb.i_clk_en = clk_en;
  assign ifa.i_delay = delay;          assign ifb.i_delay = delay;
  assign ifa.i_delay_mask = delay_mask; assign ifb.i_delay_mask = delay_mask;
  assign ifa.i_speed_select = speed;   assign ifb.i_speed_select = speed;
  assign ifa.i_overrun_clear = oclr;   assign ifb.i_overrun_clear = oclr;

  retro_catc_multi #(.CORE_CLOCK(16), .TARGET_CLOCK(4), .CHANNELS(3), .ACC_WIDTH(8),
                     .MAX_CREDIT(8), .MIN_GAP(0)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  retro_catc_multi #(.CORE_CLOCK(16), .TARGET_CLOCK(4), .CHANNELS(3), .ACC_WIDTH(8),
                     .MAX_CREDIT(4), .MIN_GAP(0)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    bit       rst_first;
    bit       en;
    bit [2:0] dly;
    bit [2:0] msk;
    bit       spd;
    int       ncyc;
    int       pulses;
    int       credit;
    int       stalled;
    int       overrun;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n clocks; sample 1 time unit after each edge and count pulses
  task automatic run(input int n);
    pa = 0;
    pb = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (ifa.o_clk_en_out) pa++;
      if (ifb.o_clk_en_out) pb++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_en = 1'b0;
    delay = '0;
    delay_mask = '0;
    speed = 1'b0;
    oclr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset clk_en_out", int'(ifa.o_clk_en_out), 0);
    check("reset credit", int'(ifa.o_credit), 0);
    check("reset stalled", int'(ifa.o_stalled), 0);
    check("reset overrun", int'(ifb.o_overrun), 0);
  endtask

  initial begin
    //          rst en dly     msk     spd ncyc pulses credit stalled overrun
    vecs[0]  = '{1, 1, 3'b000, 3'b000, 0, 100, 25, 0, 0, 0}; // free-running cadence
    vecs[1]  = '{0, 1, 3'b010, 3'b000, 0,  12,  0, 3, 1, 0}; // stall banks 3 ticks
    vecs[2]  = '{0, 1, 3'b000, 3'b000, 0,   5,  4, 0, 0, 0}; // replay burst
    vecs[3]  = '{0, 1, 3'b000, 3'b000, 0, 183, 46, 0, 0, 0}; // 200-cycle total = 50
    vecs[4]  = '{0, 1, 3'b010, 3'b010, 0,  40, 10, 0, 0, 0}; // masked delay ignored
    vecs[5]  = '{0, 1, 3'b010, 3'b000, 0,   8,  0, 2, 1, 0}; // unmasked -> stall
    vecs[6]  = '{0, 1, 3'b000, 3'b000, 0,   8,  4, 0, 0, 0}; // catch-up then run
    vecs[7]  = '{0, 1, 3'b000, 3'b000, 1,  20, 10, 0, 0, 0}; // double speed
    vecs[8]  = '{0, 1, 3'b001, 3'b000, 1,   6,  0, 3, 1, 0}; // stall at double speed
    vecs[9]  = '{0, 0, 3'b000, 3'b000, 1,  10,  0, 3, 0, 0}; // paused, credit frozen
    vecs[10] = '{0, 1, 3'b000, 3'b000, 1,  10,  8, 0, 0, 0}; // resume and replay

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rst_first) do_reset();
      clk_en     = vecs[i].en;
      delay      = vecs[i].dly;
      delay_mask = vecs[i].msk;
      speed      = vecs[i].spd;
      run(vecs[i].ncyc);
      check($sformatf("row%0d pulses", i), pa, vecs[i].pulses);
      check($sformatf("row%0d credit", i), int'(ifa.o_credit), vecs[i].credit);
      check($sformatf("row%0d stalled", i), int'(ifa.o_stalled), vecs[i].stalled);
      check($sformatf("row%0d overrun", i), int'(ifa.o_overrun), vecs[i].overrun);
    end

    // Saturation on B: 10 ticks while stalled, credit caps at 4
    do_reset();
    clk_en = 1'b1;
    delay  = 3'b001;
    run(40);
    check("sat pulses", pb, 0);
    check("sat credit", int'(ifb.o_credit), 4);
    check("sat overrun", int'(ifb.o_overrun), 1);
    check("sat stalled", int'(ifb.o_stalled), 1);
    oclr = 1'b1;             // no tick this cycle: clear takes effect
    run(1);
    check("overrun cleared", int'(ifb.o_overrun), 0);
    run(3);                  // third cycle drops a tick with clear still high
    check("overrun set wins", int'(ifb.o_overrun), 1);
    oclr = 1'b0;
    run(1);
    check("overrun sticky", int'(ifb.o_overrun), 1);

    // Asynchronous reset during catch-up with 5 credits left
    do_reset();
    clk_en = 1'b1;
    delay  = 3'b001;
    run(24);
    check("pre stall credit", int'(ifa.o_credit), 6);
    delay = 3'b000;
    run(2);
    check("catchup credit", int'(ifa.o_credit), 5);
    check("catchup pulse", int'(ifa.o_clk_en_out), 1);
    check("catchup B overrun", int'(ifb.o_overrun), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async clk_en_out", int'(ifa.o_clk_en_out), 0);
    check("async credit", int'(ifa.o_credit), 0);
    check("async overrun", int'(ifb.o_overrun), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(8);
    check("resume pulses", pa, 2);
    check("resume credit", int'(ifa.o_credit), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
